// File: rtl/radar_tx_timing.sv
// Pulse-period sequencer for the radar transmitter: TX / switch settle / receive look / idle gap,
// with a linear-FM frequency word and phase accumulator driven during TX.
module radar_tx_timing #(
    parameter int CW = 32,
    parameter int PW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ena_i,
    input  logic [CW-1:0] ton_i,
    input  logic [CW-1:0] tsw_i,
    input  logic [CW-1:0] tlook_i,
    input  logic [CW-1:0] tidle_i,
    input  logic [CW-1:0] fstart_i,
    input  logic [CW-1:0] fincr_i,
    output logic          tx_on_o,
    output logic          rx_ena_o,
    output logic          pulse_start_o,
    output logic [CW-1:0] freq_o,
    output logic [CW-1:0] phase_o,
    output logic [PW-1:0] pulse_num_o
);

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        TX   = 5'b00010,
        SW   = 5'b00100,
        LOOK = 5'b01000,
        WAIT = 5'b10000
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] tsw_sh, tlook_sh, tidle_sh, fincr_sh;
    logic          expired;
    logic          enter_tx;

    // A programmed duration of 0 dwells for one clock, same as 1.
    function automatic logic [CW-1:0] dwell_load(input logic [CW-1:0] d);
        return (d == '0) ? '0 : d - CW'(1);
    endfunction

    assign expired  = (cnt == '0);
    assign enter_tx = (state_nxt == TX) && (state != TX);

    always_comb begin
        state_nxt = state;
        if (!ena_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = TX;
                TX:      if (expired) state_nxt = SW;
                SW:      if (expired) state_nxt = LOOK;
                LOOK:    if (expired) state_nxt = WAIT;
                WAIT:    if (expired) state_nxt = TX;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // TX duration comes straight from the port: it is captured at the same edge as the shadows.
    always_comb begin
        cnt_nxt = cnt - CW'(1);
        if (state_nxt != state) begin
            case (state_nxt)
                TX:      cnt_nxt = dwell_load(ton_i);
                SW:      cnt_nxt = dwell_load(tsw_sh);
                LOOK:    cnt_nxt = dwell_load(tlook_sh);
                WAIT:    cnt_nxt = dwell_load(tidle_sh);
                default: cnt_nxt = '0;
            endcase
        end else if (state_nxt == IDLE) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            cnt           <= '0;
            tsw_sh        <= '0;
            tlook_sh      <= '0;
            tidle_sh      <= '0;
            fincr_sh      <= '0;
            tx_on_o       <= 1'b0;
            rx_ena_o      <= 1'b0;
            pulse_start_o <= 1'b0;
            freq_o        <= '0;
            phase_o       <= '0;
            pulse_num_o   <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            tx_on_o       <= (state_nxt == TX);
            rx_ena_o      <= (state_nxt == LOOK);
            pulse_start_o <= enter_tx;
            if (enter_tx) begin
                tsw_sh   <= tsw_i;
                tlook_sh <= tlook_i;
                tidle_sh <= tidle_i;
                fincr_sh <= fincr_i;
                freq_o   <= fstart_i;
                phase_o  <= '0;
                if (state == WAIT) pulse_num_o <= pulse_num_o + PW'(1);
            end else if (state_nxt == TX) begin
                freq_o  <= freq_o + fincr_sh;
                phase_o <= phase_o + freq_o;
            end else begin
                freq_o  <= '0;
                phase_o <= '0;
            end
            if (state_nxt == IDLE) pulse_num_o <= '0;
        end
    end

endmodule

// File: tb/tb_radar_tx_timing.sv
// Directed bench for radar_tx_timing: nominal period, shadowing, aborts, zero dwell, wrap, negative sweep.
module tb_radar_tx_timing;

    logic        clk_i = 1'b0;
    logic        rst_i, ena_i;
    logic [31:0] ton_i, tsw_i, tlook_i, tidle_i, fstart_i, fincr_i;
    logic        tx_on_o, rx_ena_o, pulse_start_o;
    logic [31:0] freq_o, phase_o;
    logic [15:0] pulse_num_o;
    logic        w_tx, w_rx, w_ps;
    logic [31:0] w_freq, w_phase;
    logic [2:0]  w_pn;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    radar_tx_timing dut (
        .clk_i(clk_i), .rst_i(rst_i), .ena_i(ena_i),
        .ton_i(ton_i), .tsw_i(tsw_i), .tlook_i(tlook_i), .tidle_i(tidle_i),
        .fstart_i(fstart_i), .fincr_i(fincr_i),
        .tx_on_o(tx_on_o), .rx_ena_o(rx_ena_o), .pulse_start_o(pulse_start_o),
        .freq_o(freq_o), .phase_o(phase_o), .pulse_num_o(pulse_num_o)
    );

    // Narrow pulse counter so the wrap is reachable in a short run.
    radar_tx_timing #(.CW(32), .PW(3)) dut_w (
        .clk_i(clk_i), .rst_i(rst_i), .ena_i(ena_i),
        .ton_i(ton_i), .tsw_i(tsw_i), .tlook_i(tlook_i), .tidle_i(tidle_i),
        .fstart_i(fstart_i), .fincr_i(fincr_i),
        .tx_on_o(w_tx), .rx_ena_o(w_rx), .pulse_start_o(w_ps),
        .freq_o(w_freq), .phase_o(w_phase), .pulse_num_o(w_pn)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic tx, input logic rx, input logic ps,
                              input logic [31:0] f, input logic [31:0] p, input logic [31:0] pn);
        chk({tag, ".tx"},    32'(tx_on_o),       32'(tx));
        chk({tag, ".rx"},    32'(rx_ena_o),      32'(rx));
        chk({tag, ".ps"},    32'(pulse_start_o), 32'(ps));
        chk({tag, ".freq"},  freq_o,             f);
        chk({tag, ".phase"}, phase_o,            p);
        chk({tag, ".pnum"},  32'(pulse_num_o),   pn);
    endtask

    initial begin
        int k;
        logic tx_e, rx_e;
        logic [31:0] f_e, p_e;

        rst_i = 1'b1; ena_i = 1'b0;
        ton_i = 0; tsw_i = 0; tlook_i = 0; tidle_i = 0; fstart_i = 0; fincr_i = 0;
        tick(); tick();
        check_outs("reset", 0, 0, 0, 0, 0, 0);
        rst_i = 1'b0;
        tick();
        check_outs("idle", 0, 0, 0, 0, 0, 0);

        // Nominal period; ton changes during LOOK of pulse 0 and only affects pulse 1.
        ton_i = 4; tsw_i = 2; tlook_i = 8; tidle_i = 3; fstart_i = 100; fincr_i = 10;
        ena_i = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            tick();
            tx_e = (c >= 1 && c <= 4) || (c >= 18 && c <= 27);
            rx_e = (c >= 7 && c <= 14);
            k = (c >= 18) ? c - 18 : c - 1;
            f_e = tx_e ? 32'(100 + 10 * k) : 32'd0;
            p_e = tx_e ? 32'(100 * k + 5 * k * (k - 1)) : 32'd0;
            check_outs($sformatf("nom c%0d", c), tx_e, rx_e, (c == 1 || c == 18), f_e, p_e,
                       (c >= 18) ? 32'd1 : 32'd0);
            if (c == 8) ton_i = 10;
        end

        ena_i = 1'b0;
        tick();
        check_outs("stop", 0, 0, 0, 0, 0, 0);

        // Negative sweep, restart from IDLE with pulse number 0.
        ton_i = 3; fstart_i = 50; fincr_i = 32'hFFFF_FFFB;
        ena_i = 1'b1;
        tick(); check_outs("neg k0", 1, 0, 1, 50, 0, 0);
        tick(); check_outs("neg k1", 1, 0, 0, 45, 50, 0);
        tick(); check_outs("neg k2", 1, 0, 0, 40, 95, 0);
        tick(); check_outs("neg sw", 0, 0, 0, 0, 0, 0);

        // Abort by ena_i at TX cycle 2.
        ena_i = 1'b0;
        tick();
        ton_i = 4; fstart_i = 100; fincr_i = 10;
        ena_i = 1'b1;
        tick(); tick(); tick();
        check_outs("abort k2", 1, 0, 0, 120, 210, 0);
        ena_i = 1'b0;
        tick();
        check_outs("abort ena", 0, 0, 0, 0, 0, 0);

        // Zero durations: 4-clock period; narrow counter wraps 7 -> 0.
        ton_i = 0; tsw_i = 0; tlook_i = 0; tidle_i = 0; fstart_i = 7; fincr_i = 1;
        ena_i = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            tx_e = ((c - 1) % 4 == 0);
            rx_e = ((c - 1) % 4 == 2);
            check_outs($sformatf("zero c%0d", c), tx_e, rx_e, tx_e, tx_e ? 32'd7 : 32'd0, 0,
                       32'((c - 1) / 4));
            chk($sformatf("zero sep c%0d", c), 32'(tx_on_o & rx_ena_o), 0);
            chk($sformatf("pnwrap c%0d", c), 32'(w_pn), 32'(((c - 1) / 4) % 8));
        end

        // Reset during LOOK behaves like ena_i low; rst_i wins over ena_i.
        tick(); tick(); tick();
        check_outs("look", 0, 1, 0, 0, 0, 10);
        rst_i = 1'b1;
        tick();
        check_outs("abort rst", 0, 0, 0, 0, 0, 0);
        rst_i = 1'b0;
        tick();
        check_outs("restart", 1, 0, 1, 7, 0, 0);

        // Frequency and phase wrap silently.
        ena_i = 1'b0;
        tick();
        ton_i = 3; fstart_i = 32'hFFFF_FFF0; fincr_i = 32'h10;
        ena_i = 1'b1;
        tick(); check_outs("wrap k0", 1, 0, 1, 32'hFFFF_FFF0, 0, 0);
        tick(); check_outs("wrap k1", 1, 0, 0, 32'h0, 32'hFFFF_FFF0, 0);
        tick(); check_outs("wrap k2", 1, 0, 0, 32'h10, 32'hFFFF_FFF0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
